// File: rtl/cell_decoder_if.sv
// Cell-select bus between move-select logic and the cell decoder.
// master drives the cell index; slave returns the registered enables.
interface cell_decoder_if;
    logic [3:0] sel;
    logic       en1;
    logic       en2;
    logic       en3;
    logic       en4;
    logic       en5;
    logic       en6;
    logic       en7;
    logic       en8;
    logic       en9;
    logic [8:0] en_bus;
    logic       any_en;
    logic       sel_error;

    modport master (
        output sel,
        input  en1, en2, en3, en4, en5, en6, en7, en8, en9,
        input  en_bus, any_en, sel_error
    );

    modport slave (
        input  sel,
        output en1, en2, en3, en4, en5, en6, en7, en8, en9,
        output en_bus, any_en, sel_error
    );
endinterface

// File: rtl/cell_decoder.sv
// Registered 4-to-9 one-hot cell decoder for the tic-tac-toe board.
// Indices 9-15 give no enable and set sel_error for that cycle.
module cell_decoder (
    input  logic           i_clk,
    input  logic           i_rst,
    cell_decoder_if.slave  bus
);

    logic [8:0] w_en;
    logic       w_any_en;
    logic       w_sel_error;
    logic [8:0] r_en;
    logic       r_any_en;
    logic       r_sel_error;

    function automatic logic [8:0] decode_cell(input logic [3:0] sel);
        logic [8:0] en;
        case (sel)
            4'd0:    en = 9'h001;
            4'd1:    en = 9'h002;
            4'd2:    en = 9'h004;
            4'd3:    en = 9'h008;
            4'd4:    en = 9'h010;
            4'd5:    en = 9'h020;
            4'd6:    en = 9'h040;
            4'd7:    en = 9'h080;
            4'd8:    en = 9'h100;
            default: en = 9'h000;
        endcase
        return en;
    endfunction

    // Next-state decode of the sampled cell index.
    always_comb begin
        w_en        = decode_cell(bus.sel);
        w_any_en    = |w_en;
        w_sel_error = (bus.sel > 4'd8) ? 1'b1 : 1'b0;
    end

    // Output registers; reset wins over any sel on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en        <= 9'h000;
            r_any_en    <= 1'b0;
            r_sel_error <= 1'b0;
        end else begin
            r_en        <= w_en;
            r_any_en    <= w_any_en;
            r_sel_error <= w_sel_error;
        end
    end

    // Packed bus and individual lines share one register so they cannot disagree.
    assign bus.en_bus    = r_en;
    assign bus.en1       = r_en[0];
    assign bus.en2       = r_en[1];
    assign bus.en3       = r_en[2];
    assign bus.en4       = r_en[3];
    assign bus.en5       = r_en[4];
    assign bus.en6       = r_en[5];
    assign bus.en7       = r_en[6];
    assign bus.en8       = r_en[7];
    assign bus.en9       = r_en[8];
    assign bus.any_en    = r_any_en;
    assign bus.sel_error = r_sel_error;

endmodule

// File: tb/tb_cell_decoder.sv
// Scoreboard bench for cell_decoder: directed plan followed by random sel/reset traffic.
module tb_cell_decoder;

    logic clk;
    logic rst;
    cell_decoder_if bus ();

    cell_decoder dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] en;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   drive_done = 1'b0;

    // Reference: the enabled cell is sel+1 when sel names a cell, else none.
    function automatic exp_t model(input logic r, input logic [3:0] s);
        exp_t e;
        int   idx;
        idx = int'(s);
        e.en  = 9'h000;
        e.err = 1'b0;
        if (!r) begin
            if (idx < 9) e.en[idx] = 1'b1;
            else         e.err = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [19:0] observed();
        return {bus.en_bus,
                bus.en9, bus.en8, bus.en7, bus.en6, bus.en5,
                bus.en4, bus.en3, bus.en2, bus.en1,
                bus.any_en, bus.sel_error};
    endfunction

    function automatic logic [19:0] wanted(input exp_t e);
        return {e.en, e.en, (e.en != 9'h000), e.err};
    endfunction

    task automatic compare(input string name, input exp_t e);
        logic [19:0] act;
        logic [19:0] req;
        act = observed();
        req = wanted(e);
        vectors++;
        if (act !== req || $countones(bus.en_bus) > 1) begin
            miscompares++;
            $display("FAIL %s at %0t: got en_bus=%h en9..1=%b any=%b err=%b, want en_bus=%h any=%b err=%b",
                     name, $time, act[19:11], act[10:2], act[1], act[0],
                     req[19:11], req[1], req[0]);
        end
    endtask

    // Inputs change on the falling edge; expectation is for the next rising edge.
    task automatic apply(input logic r, input logic [3:0] s);
        @(negedge clk);
        rst     = r;
        bus.sel = s;
        q.push_back(model(r, s));
    endtask

    // Monitor: check after each rising edge, then confirm outputs hold mid-cycle.
    initial begin
        exp_t cur;
        bit   have = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                cur  = q.pop_front();
                have = 1'b1;
                compare("post_edge", cur);
            end
            @(negedge clk);
            #1;
            if (have) compare("mid_cycle_hold", cur);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, queue=%0d", q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] s;
        logic       r;
        rst     = 1'b1;
        bus.sel = 4'd4;
        apply(1'b1, 4'd4);
        apply(1'b1, 4'd4);
        for (int i = 0; i < 9; i++) apply(1'b0, 4'(i));
        apply(1'b0, 4'd9);
        apply(1'b0, 4'd15);
        apply(1'b0, 4'd2);
        apply(1'b0, 4'd0);
        apply(1'b0, 4'd8);
        for (int i = 0; i < 10; i++) apply(1'b0, 4'd5);
        apply(1'b0, 4'd7);
        apply(1'b0, 4'd7);
        apply(1'b1, 4'd7);
        apply(1'b0, 4'd7);
        apply(1'b0, 4'd7);
        for (int i = 0; i < 400; i++) begin
            s = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            apply(r, s);
        end
        drive_done = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
